// File: rtl/project_select_ctrl.sv
// project_select_ctrl
//   Chooses which user project is active, drives per-project clock enables
//   and a shared project reset, and sequences every project change as
//   DRAIN (old project held in reset, still clocked) -> SWITCH (all clocks
//   gated, index updated) -> RELEASE (new project clocked, held in reset)
//   -> RUN. The selection comes either from debounced IO pins or from a
//   Wishbone control register.
//
// Ports
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   wbs_*                  : Wishbone slave (control register at CFG_ADDRESS)
//   hit_o                  : combinational address match for the wrapper mux
//   pin_sel_i              : asynchronous selection pins
//   configuration_o        : active project index
//   proj_clk_en_o          : one-hot project clock enables
//   proj_rst_o             : shared project reset
//   busy_o                 : high while a project change (or reset release) runs
//
// Control register layout
//   [CFG_BITS-1:0]  configuration_o (RO)
//   [8+:CFG_BITS]   SW_SEL (RW, byte lane 1)
//   [16]            SRC    (RW, byte lane 2; 1 = SW_SEL, 0 = pins)
//   [17]            busy_o (RO)
//   [24+:CFG_BITS]  filtered pin value (RO)
module project_select_ctrl #(
  parameter logic [31:0] CFG_ADDRESS     = 32'h300FFFFC,
  parameter int unsigned USER_PROJECTS   = 4,
  parameter int unsigned CFG_BITS        = $clog2(USER_PROJECTS),
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RST_CYCLES      = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic                     hit_o,
  input  logic [CFG_BITS-1:0]      pin_sel_i,
  output logic [CFG_BITS-1:0]      configuration_o,
  output logic [USER_PROJECTS-1:0] proj_clk_en_o,
  output logic                     proj_rst_o,
  output logic                     busy_o
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_SWITCH,
    S_RELEASE
  } state_t;

  state_t                   r_state;
  logic [RCW-1:0]           r_cnt;
  logic [CFG_BITS-1:0]      r_target;
  logic [CFG_BITS-1:0]      r_cfg;
  logic [USER_PROJECTS-1:0] r_clk_en;
  logic                     r_proj_rst;
  logic [CFG_BITS-1:0]      r_sw_sel;
  logic                     r_src;
  logic [CFG_BITS-1:0]      r_sync1;
  logic [CFG_BITS-1:0]      r_sync2;
  logic [CFG_BITS-1:0]      r_cand;
  logic [DCW-1:0]           r_dcnt;
  logic [CFG_BITS-1:0]      r_filt;
  logic                     r_ack;
  logic [31:0]              r_dat;

  logic                     w_hit;
  logic                     w_access;
  logic                     w_busy;
  logic                     w_sw_wr_ok;
  logic [31:0]              w_rd_data;
  logic [CFG_BITS-1:0]      w_req;
  logic                     w_req_valid;
  logic [DCW-1:0]           w_dcnt_nxt;
  state_t                   w_nxt_state;
  logic [RCW-1:0]           w_nxt_cnt;
  logic [CFG_BITS-1:0]      w_nxt_target;
  logic [CFG_BITS-1:0]      w_nxt_cfg;
  logic [USER_PROJECTS-1:0] w_nxt_clk_en;
  logic                     w_nxt_rst;

  assign w_hit    = (wbs_adr_i[31:2] == CFG_ADDRESS[31:2]);
  // Blocking the cycle right after an ack makes a held strobe ack every other cycle.
  assign w_access = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
  assign w_busy   = (r_state != S_RUN);

  // The whole byte lane is range-checked so that out-of-range values wider
  // than the index field are rejected instead of being silently truncated.
  assign w_sw_wr_ok  = ({24'b0, wbs_dat_i[15:8]} < USER_PROJECTS);
  assign w_req       = r_src ? r_sw_sel : r_filt;
  assign w_req_valid = ({{(32-CFG_BITS){1'b0}}, w_req} < USER_PROJECTS);

  always_comb begin
    w_rd_data                 = '0;
    w_rd_data[CFG_BITS-1:0]   = r_cfg;
    w_rd_data[8+:CFG_BITS]    = r_sw_sel;
    w_rd_data[16]             = r_src;
    w_rd_data[17]             = w_busy;
    w_rd_data[24+:CFG_BITS]   = r_filt;
  end

  // Stable-cycle counter saturates once the candidate has been accepted.
  always_comb begin
    w_dcnt_nxt = '0;
    if (r_sync2 == r_cand) begin
      if (r_dcnt == DCW'(DEBOUNCE_CYCLES - 1)) w_dcnt_nxt = r_dcnt;
      else                                     w_dcnt_nxt = r_dcnt + DCW'(1);
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_target = r_target;
    w_nxt_cfg    = r_cfg;
    case (r_state)
      S_RUN: begin
        if (w_req_valid && (w_req != r_cfg)) begin
          w_nxt_target = w_req;
          w_nxt_state  = S_DRAIN;
          w_nxt_cnt    = RCW'(RST_CYCLES);
        end
      end
      S_DRAIN: begin
        if (r_cnt == RCW'(1)) w_nxt_state = S_SWITCH;
        else                  w_nxt_cnt   = r_cnt - RCW'(1);
      end
      S_SWITCH: begin
        w_nxt_cfg   = r_target;
        w_nxt_state = S_RELEASE;
        w_nxt_cnt   = RCW'(RST_CYCLES);
      end
      S_RELEASE: begin
        if (r_cnt == RCW'(1)) w_nxt_state = S_RUN;
        else                  w_nxt_cnt   = r_cnt - RCW'(1);
      end
      default: w_nxt_state = S_RUN;
    endcase

    // Outputs are derived from the next state so they are registered on entry.
    w_nxt_clk_en            = '0;
    w_nxt_clk_en[w_nxt_cfg] = 1'b1;
    if (w_nxt_state == S_SWITCH) w_nxt_clk_en = '0;
    w_nxt_rst = (w_nxt_state != S_RUN);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_RELEASE;
      r_cnt      <= RCW'(RST_CYCLES);
      r_target   <= '0;
      r_cfg      <= '0;
      r_clk_en   <= USER_PROJECTS'(1);
      r_proj_rst <= 1'b1;
      r_sw_sel   <= '0;
      r_src      <= 1'b0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cand     <= '0;
      r_dcnt     <= '0;
      r_filt     <= '0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_access ? w_rd_data : '0;
      if (w_access && wbs_we_i) begin
        if (wbs_sel_i[1] && w_sw_wr_ok) r_sw_sel <= wbs_dat_i[8+:CFG_BITS];
        if (wbs_sel_i[2])               r_src    <= wbs_dat_i[16];
      end

      r_sync1 <= pin_sel_i;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_dcnt  <= w_dcnt_nxt;
      if (w_dcnt_nxt == DCW'(DEBOUNCE_CYCLES - 1)) r_filt <= r_sync2;

      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_target   <= w_nxt_target;
      r_cfg      <= w_nxt_cfg;
      r_clk_en   <= w_nxt_clk_en;
      r_proj_rst <= w_nxt_rst;
    end
  end

  assign hit_o           = w_hit;
  assign wbs_ack_o       = r_ack;
  assign wbs_dat_o       = r_dat;
  assign configuration_o = r_cfg;
  assign proj_clk_en_o   = r_clk_en;
  assign proj_rst_o      = r_proj_rst;
  assign busy_o          = w_busy;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: directed scenarios followed
// by randomized traffic, all checked cycle by cycle against a reference
// model that tracks a project change as an elapsed-cycle index.
module tb_project_select_ctrl;
  localparam int NP = 4;
  localparam int CB = 2;
  localparam int D  = 4;
  localparam int R  = 4;
  localparam logic [31:0] CFG = 32'h300FFFFC;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        hit;
  logic [1:0]  pin;
  logic [1:0]  cfg;
  logic [3:0]  en;
  logic        prst, busy;

  always #5 wb_clk_i = ~wb_clk_i;

  project_select_ctrl #(
    .CFG_ADDRESS(CFG),
    .USER_PROJECTS(NP),
    .CFG_BITS(CB),
    .DEBOUNCE_CYCLES(D),
    .RST_CYCLES(R)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .hit_o(hit),
    .pin_sel_i(pin),
    .configuration_o(cfg),
    .proj_clk_en_o(en),
    .proj_rst_o(prst),
    .busy_o(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. m_t = -1 when running, otherwise the index of the
  // current cycle within a project change: 0..R-1 old project in reset,
  // R all clocks gated, R+1..2R new project in reset.
  int m_s1, m_s2, m_cand, m_len, m_filt, m_sw, m_src, m_cfg, m_tgt, m_t, m_ack;
  logic [31:0] m_dat;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_cand = 0; m_len = 1; m_filt = 0;
    m_sw = 0; m_src = 0; m_cfg = 0; m_tgt = 0;
    m_t = R + 1; m_ack = 0; m_dat = '0;
  endtask

  function automatic bit addr_hit(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) == (CFG & 32'hFFFF_FFFC);
  endfunction

  task automatic model_step();
    int n_sw, n_src, n_s1, n_s2, n_cand, n_len, n_filt, req;
    bit acc, mbusy;
    logic [31:0] rd;
    if (wb_rst_i) begin
      model_reset();
      return;
    end
    mbusy = (m_t >= 0);
    acc = stb && cyc && addr_hit(adr) && (m_ack == 0);
    rd = 32'(m_cfg) | (32'(m_sw) << 8) | (32'(m_src) << 16) |
         (32'(mbusy) << 17) | (32'(m_filt) << 24);
    n_sw = m_sw; n_src = m_src;
    if (acc && we) begin
      if (sel[1] && (int'(dat_i[15:8]) < NP)) n_sw = int'(dat_i[8 +: CB]);
      if (sel[2]) n_src = int'(dat_i[16]);
    end
    n_s1 = int'(pin);
    n_s2 = m_s1;
    if (m_s2 != m_cand) begin
      n_cand = m_s2; n_len = 1;
    end else begin
      n_cand = m_cand; n_len = (m_len + 1 > D) ? D : m_len + 1;
    end
    n_filt = (n_len >= D) ? n_cand : m_filt;
    req = (m_src != 0) ? m_sw : m_filt;
    if (m_t < 0) begin
      if (req < NP && req != m_cfg) begin
        m_tgt = req;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == R + 1) m_cfg = m_tgt;
      if (m_t == 2 * R + 1) m_t = -1;
    end
    m_ack = acc ? 1 : 0;
    m_dat = acc ? rd : '0;
    m_sw = n_sw; m_src = n_src; m_s1 = n_s1; m_s2 = n_s2;
    m_cand = n_cand; m_len = n_len; m_filt = n_filt;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    logic [31:0] exp_en;
    #1 check("hit", 32'(hit), 32'(addr_hit(adr)));
    @(posedge wb_clk_i);
    model_step();
    #1;
    exp_en = (m_t == R) ? 32'h0 : (32'h1 << m_cfg);
    check("cfg",  32'(cfg),  32'(m_cfg));
    check("clken", 32'(en),  exp_en);
    check("prst", 32'(prst), 32'(m_t >= 0));
    check("busy", 32'(busy), 32'(m_t >= 0));
    check("ack",  32'(ack),  32'(m_ack));
    check("rdat", dat_o,     m_dat);
    @(negedge wb_clk_i);
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    cycle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    int k;
    wb_rst_i = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = '0; dat_i = '0; adr = '0; pin = '0;
    model_reset();
    @(negedge wb_clk_i);
    repeat (2) cycle();
    wb_rst_i = 1'b0;
    repeat (10) cycle();
    check("t1_clken", 32'(en), 32'h1);

    pin = 2'd2;
    repeat (20) cycle();
    check("t2_cfg", 32'(cfg), 32'd2);

    pin = 2'd3;
    repeat (2) cycle();
    pin = 2'd2;
    repeat (12) cycle();
    check("t3_cfg", 32'(cfg), 32'd2);

    pin = 2'd0;
    repeat (20) cycle();
    wb(1'b1, CFG, 32'h0001_0300, 4'b0110);
    repeat (20) cycle();
    check("t4_cfg", 32'(cfg), 32'd3);
    wb(1'b0, CFG, 32'h0, 4'hF);
    cycle();

    wb(1'b1, CFG, 32'h0000_0500, 4'b0010);
    repeat (3) cycle();
    wb(1'b1, CFG - 32'd4, 32'h0000_0100, 4'b0010);
    repeat (3) cycle();
    check("t5_cfg", 32'(cfg), 32'd3);

    wb(1'b1, CFG, 32'h0001_0100, 4'b0010);
    k = 0;
    while (m_t != R && k < 40) begin
      cycle();
      k++;
    end
    check("t6_switch_reached", 32'(m_t == R), 32'd1);
    wb_rst_i = 1'b1;
    cycle();
    wb_rst_i = 1'b0;
    repeat (12) cycle();
    check("t6_cfg", 32'(cfg), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      wb_rst_i = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) pin = 2'($urandom_range(0, 3));
      stb = ($urandom_range(0, 3) == 0);
      cyc = ($urandom_range(0, 7) != 0);
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    adr = CFG;
        2:       adr = (CFG & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        default: adr = $urandom;
      endcase
      dat_i = $urandom;
      dat_i[15:8] = 8'($urandom_range(0, 5));
      cycle();
    end
    wb_rst_i = 1'b0; stb = 1'b0; cyc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
